// File: rtl/prng_health_monitor.sv
// prng_health_monitor: continuous repetition-count and adaptive-proportion
// health tests on a random sample stream. Passing samples are buffered in a
// first-word-fall-through FIFO; any test failure raises a sticky alarm and
// blocks the stream until clear_alarm starts a new warm-up epoch.
module prng_health_monitor #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RCT_CUTOFF = 4,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 8,
  parameter int WARMUP     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          sample_valid,
  input  logic                          clear_alarm,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rct_fail,
  output logic                          apt_fail,
  output logic [1:0]                    state,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int MW = $clog2(APT_CUTOFF + 1);
  localparam int WW = $clog2(APT_WINDOW);
  localparam int CW = $clog2(WARMUP + 1);

  localparam logic [RW-1:0] RCT_MAX   = RW'(RCT_CUTOFF);
  localparam logic [MW-1:0] APT_MAX   = MW'(APT_CUTOFF);
  localparam logic [WW-1:0] W_LAST    = WW'(APT_WINDOW - 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'b00,
    ST_RUN    = 2'b01,
    ST_ALARM  = 2'b10
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] prev;
  logic             prev_vld;
  logic [RW-1:0]    rep;
  logic [WIDTH-1:0] apt_ref;
  logic [MW-1:0]    match;
  logic [WW-1:0]    w;
  logic [CW-1:0]    warm_cnt;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;

  logic [RW-1:0]    rep_nxt;
  logic [WIDTH-1:0] ref_nxt;
  logic [MW-1:0]    match_nxt;
  logic [WW-1:0]    w_nxt;
  logic             accept, rct_trip, apt_trip, trip;
  logic             full, pop, pass_run, push, drop;

  assign state      = st;
  assign fifo_level = level;
  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign full       = (level == LVL_FULL);
  assign pop        = out_valid && out_ready;

  // clear_alarm blocks acceptance in every state so the clearing edge never
  // consumes a sample
  assign accept = sample_valid && (st != ST_ALARM) && !clear_alarm;

  // Next values of both health tests for the sample currently presented
  always_comb begin
    rep_nxt   = RW'(1);
    ref_nxt   = apt_ref;
    match_nxt = match;
    if (prev_vld && (sample_in == prev))
      rep_nxt = (rep == RCT_MAX) ? rep : rep + 1'b1;
    if (w == '0) begin
      ref_nxt   = sample_in;
      match_nxt = MW'(1);
    end else if (sample_in == apt_ref) begin
      match_nxt = match + 1'b1;
    end
    w_nxt = (w == W_LAST) ? '0 : w + 1'b1;
  end

  assign rct_trip = accept && (rep_nxt == RCT_MAX);
  assign apt_trip = accept && (match_nxt == APT_MAX);
  assign trip     = rct_trip || apt_trip;
  assign pass_run = accept && !trip && (st == ST_RUN);
  assign push     = pass_run && (!full || pop);
  assign drop     = pass_run && full && !pop;

  // Mode FSM together with the test state it owns
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_WARMUP;
      prev     <= '0;
      prev_vld <= 1'b0;
      rep      <= '0;
      apt_ref  <= '0;
      match    <= '0;
      w        <= '0;
      warm_cnt <= '0;
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
    end else begin
      case (st)
        ST_ALARM: begin
          if (clear_alarm) begin
            st       <= ST_WARMUP;
            prev_vld <= 1'b0;
            rep      <= '0;
            match    <= '0;
            w        <= '0;
            warm_cnt <= '0;
            rct_fail <= 1'b0;
            apt_fail <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            prev     <= sample_in;
            prev_vld <= 1'b1;
            rep      <= rep_nxt;
            apt_ref  <= ref_nxt;
            match    <= match_nxt;
            w        <= w_nxt;
            if (trip) begin
              rct_fail <= rct_fail | rct_trip;
              apt_fail <= apt_fail | apt_trip;
              st       <= ST_ALARM;
            end else if (st == ST_WARMUP) begin
              warm_cnt <= warm_cnt + 1'b1;
              if (warm_cnt == WARM_LAST) st <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a trip flushes everything on the same edge
  always_ff @(posedge clk) begin
    if (rst || trip) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // FIFO storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // Saturating count of RUN samples lost to a full FIFO
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 1'b1;
  end

endmodule

// File: tb/tb_prng_health_monitor.sv
// Directed bench for prng_health_monitor: warm-up, backpressure/drop, RCT trip,
// APT window behaviour, clear_alarm handling and mid-run reset.
module tb_prng_health_monitor;

  logic        clk = 1'b0;
  logic        rst, sample_valid, clear_alarm, out_ready;
  logic [15:0] sample_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  fifo_level;
  logic        rct_fail, apt_fail;
  logic [1:0]  state;
  logic [15:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  prng_health_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .clear_alarm (clear_alarm),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .rct_fail    (rct_fail),
    .apt_fail    (apt_fail),
    .state       (state),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change on the falling edge, outputs are read on the next falling edge
  task automatic step(input logic v, input logic [15:0] d);
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1; sample_valid = 1'b0; clear_alarm = 1'b0; out_ready = 1'b1; sample_in = '0;
    @(negedge clk);
    step(1'b0, 16'h0);
    rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_flags", 32'({rct_fail, apt_fail}), 0);
    chk("rst_drop",  32'(drop_count), 0);

    // warm-up: samples 1..16 discarded
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 16'(i));
      if (i == 15) chk("warm15_state", 32'(state), 0);
    end
    chk("warm_done_state", 32'(state), 1);
    chk("warm_no_out", 32'(out_valid), 0);
    step(1'b1, 16'd17);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_data", 32'(out_data), 17);
    chk("first_flags", 32'({rct_fail, apt_fail}), 0);
    step(1'b0, 16'h0);
    chk("drained", 32'(fifo_level), 0);

    // backpressure: 20 samples into an 8-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 16'(16'h100 + i));
    chk("bp_level", 32'(fifo_level), 8);
    chk("bp_drop", 32'(drop_count), 12);
    chk("bp_hold", 32'(out_data), 32'h100);
    out_ready = 1'b1;
    step(1'b1, 16'h114);
    chk("full_pushpop_level", 32'(fifo_level), 8);
    chk("full_pushpop_drop", 32'(drop_count), 12);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(out_data), (i < 7) ? 32'(16'h101 + i) : 32'h114);
      step(1'b0, 16'h0);
    end
    chk("drain_empty", 32'(out_valid), 0);

    // RCT: fourth identical sample trips
    step(1'b1, 16'h200);
    step(1'b1, 16'h201);
    step(1'b1, 16'hAAAA);
    chk("rct_fwd1", 32'(out_data), 32'hAAAA);
    step(1'b1, 16'hAAAA);
    step(1'b1, 16'hAAAA);
    chk("rct_pre_flag", 32'(rct_fail), 0);
    chk("rct_fwd3_data", 32'(out_data), 32'hAAAA);
    chk("rct_fwd3_level", 32'(fifo_level), 1);
    step(1'b1, 16'hAAAA);
    chk("rct_flag", 32'(rct_fail), 1);
    chk("rct_state", 32'(state), 2);
    chk("rct_apt_clear", 32'(apt_fail), 0);
    chk("rct_flush_level", 32'(fifo_level), 0);
    chk("rct_flush_valid", 32'(out_valid), 0);
    step(1'b1, 16'h0BAD);
    chk("alarm_hold_state", 32'(state), 2);
    chk("alarm_no_write", 32'(fifo_level), 0);

    // clear_alarm in ALARM: new epoch, drop_count kept
    clear_alarm = 1'b1;
    step(1'b1, 16'h5555);
    clear_alarm = 1'b0;
    chk("clr_state", 32'(state), 0);
    chk("clr_flags", 32'({rct_fail, apt_fail}), 0);
    chk("clr_drop_keep", 32'(drop_count), 12);

    // APT window 1: ref 0x1234 with 7 occurrences total, no trip
    for (int i = 0; i < 64; i++) begin
      v = ((i % 2 == 0) && (i <= 12)) ? 16'h1234 : 16'(16'h600 + i);
      step(1'b1, v);
      if (i == 14) chk("w1_warm_state", 32'(state), 0);
      if (i == 15) begin
        chk("w1_run_state", 32'(state), 1);
        chk("w1_warm_discard", 32'(out_valid), 0);
        // clear_alarm outside ALARM: no state change and sample not accepted
        clear_alarm = 1'b1;
        step(1'b1, 16'h1234);
        clear_alarm = 1'b0;
        chk("clr_run_state", 32'(state), 1);
        chk("clr_run_nowrite", 32'(out_valid), 0);
        chk("clr_run_apt", 32'(apt_fail), 0);
      end
    end
    chk("w1_apt", 32'(apt_fail), 0);
    chk("w1_rct", 32'(rct_fail), 0);
    chk("w1_state", 32'(state), 1);
    chk("w1_last_data", 32'(out_data), 32'h63F);
    chk("w1_level", 32'(fifo_level), 1);

    // APT window 2: ref recaptured as 0x5678, trips on its 8th occurrence
    for (int j = 0; j < 15; j++) begin
      v = (j == 1) ? 16'h1234 : (j % 2 == 0) ? 16'h5678 : 16'(16'h700 + j);
      step(1'b1, v);
      if (j == 12) begin
        chk("w2_pre_apt", 32'(apt_fail), 0);
        chk("w2_pre_state", 32'(state), 1);
      end
    end
    chk("w2_apt", 32'(apt_fail), 1);
    chk("w2_rct", 32'(rct_fail), 0);
    chk("w2_state", 32'(state), 2);
    chk("w2_flush", 32'(fifo_level), 0);

    // mid-RUN reset with 5 entries queued
    clear_alarm = 1'b1;
    step(1'b0, 16'h0);
    clear_alarm = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h800 + i));
    chk("g_run_state", 32'(state), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h900 + i));
    chk("g_level", 32'(fifo_level), 5);
    chk("g_head", 32'(out_data), 32'h900);
    chk("g_drop_keep", 32'(drop_count), 12);
    rst = 1'b1; clear_alarm = 1'b1; out_ready = 1'b1;
    step(1'b1, 16'hFFFF);
    rst = 1'b0; clear_alarm = 1'b0;
    chk("mrst_state", 32'(state), 0);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_flags", 32'({rct_fail, apt_fail}), 0);
    chk("mrst_drop", 32'(drop_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prng_health_monitor.md
Name: prng_health_monitor

Overview:
- Downstream consumer of the multi-LFSR generator: takes its 16-bit random_number stream and runs continuous health tests on it.
- Tests are a repetition-count test (RCT) and an adaptive-proportion test (APT).
- Passing samples are buffered in a small FWFT FIFO with a valid/ready output; on a test failure the stream is blocked and a sticky alarm is raised.
- A new seed epoch is started by clear_alarm, which forces a warm-up discard period.

Parameters:
- WIDTH, 16, sample width.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
- RCT_CUTOFF, 4, number of consecutive identical samples that trips RCT.
- APT_WINDOW, 64, APT window length in accepted samples.
- APT_CUTOFF, 8, number of matches to the window reference that trips APT.
- WARMUP, 16, number of accepted samples discarded after reset or clear_alarm.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  WIDTH  generator output (random_number).
- sample_valid  in  1  sample_in is accepted on this edge; may be tied high.
- clear_alarm  in  1  exits ALARM; ignored in other states.
- out_data  out  WIDTH  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- rct_fail  out  1  sticky RCT alarm.
- apt_fail  out  1  sticky APT alarm.
- state  out  2  00 WARMUP, 01 RUN, 10 ALARM.
- drop_count  out  16  samples dropped in RUN because the FIFO was full; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at an edge): state=WARMUP; FIFO emptied; out_data=0, out_valid=0, fifo_level=0, rct_fail=0, apt_fail=0, drop_count=0. All internal counters and the prev-valid flag are cleared. rst overrides every other input.
- Accept condition: sample_valid=1, state≠ALARM, clear_alarm=0.
- RCT, per accepted sample:
  - If prev-valid and sample==prev: rep=rep+1, saturating at RCT_CUTOFF. Otherwise rep=1.
  - Then prev=sample and prev-valid=1.
  - Trip when the updated rep equals RCT_CUTOFF.
- APT, per accepted sample, window index w:
  - At w=0: ref=sample, match=1.
  - At w>0: if sample==ref, match=match+1.
  - Trip when the updated match equals APT_CUTOFF.
  - w wraps from APT_WINDOW-1 to 0.
- On a trip:
  - The relevant flag(s) are registered and visible after the accepting edge.
  - state goes to ALARM on the same edge.
  - The tripping sample is not written to the FIFO.
  - Both flags may set on the same edge.
- WARMUP: accepted samples run through RCT and APT but are never written. After the WARMUP-th accepted sample (itself discarded), state goes to RUN. A trip during WARMUP goes to ALARM.
- RUN: a passing accepted sample is written if the FIFO is not full, or if it is full with a pop on the same edge. Otherwise it is dropped and drop_count increments (saturating).
- ALARM:
  - The FIFO is flushed on the entry edge, so out_valid=0 and fifo_level=0 on the next cycle.
  - No writes or test updates occur in ALARM.
  - clear_alarm=1: clears both flags, rep, match, w and prev-valid, resets the warm-up counter, and moves to WARMUP.
  - drop_count is not cleared by clear_alarm.
  - A sample presented on the clear_alarm edge is discarded.
- FIFO:
  - First-word fall-through; out_valid = !empty; pop when out_valid && out_ready.
  - Latency: when the FIFO is empty, a sample written at edge N appears on out_data/out_valid after edge N (1 cycle).
  - Simultaneous push and pop: when full, level is unchanged; when empty, push only.
  - Order is strictly FIFO; pointers wrap modulo FIFO_DEPTH.
  - out_data holds its value while out_valid=1 and out_ready=0.

Test Plan:
- Reset; sample_valid=1; sample_in=1,2,3,…; out_ready=1 → samples 1..16 discarded; state=01 after the 16th edge; first out_data=17 one cycle after it is accepted; no flags set.
- After warm-up, stream distinct values then 0xAAAA ×4 → first three 0xAAAA are forwarded; rct_fail=1 and state=10 after the 4th; next cycle fifo_level=0 and out_valid=0; apt_fail=0.
- APT: window reference 0x1234 recurs 8 times within 64 samples, no back-to-back repeats → apt_fail=1 after the 8th. The same stimulus with 7 recurrences → no fail; at sample 65 ref is re-captured and match=1.
- Backpressure: out_ready=0 in RUN with 20 distinct samples → fifo_level=8 and drop_count=12. Then out_ready=1 → out_data is the first 8 samples in order, then out_valid=0.
- clear_alarm=1 in ALARM → both flags 0 and state=00 next cycle; the next 16 samples are discarded; drop_count is retained. clear_alarm=1 in RUN → no change.
- rst=1 mid-RUN with fifo_level=5 → next cycle all outputs 0 and state=00, independent of clear_alarm and out_ready.
